// File: rtl/auteur_delay_align.sv
// -----------------------------------------------------------------------------
// auteur_delay_align
//   Handshaked delay-balancing pipeline with a delay that can be changed at
//   runtime. It aligns one datapath branch with a sibling branch, for example
//   the exponent path against the mantissa path, or the scale path against the
//   input path. NumLanes lanes of Width bits move through a lockstep shift
//   pipeline, and the output tap is stage D-1 for an active delay D. With D=0
//   the block is a combinational bypass. Bubbles are never compressed, so the
//   alignment with sibling paths is preserved.
//
// Optional feature (macro AUTEUR_DELAY_ALIGN_OCCUPANCY_EN):
//   Adds occupancy_o, a count of the valid beats currently held in the stages.
//
// Ports:
//   clk_i        clock
//   rst_ni       synchronous active-low reset (control state only)
//   flush_i      drop all in-flight beats at the next edge
//   in_valid_i   input beat valid
//   in_ready_o   input beat accepted when high together with in_valid_i
//   in_data_i    input payload, lane k at [k*Width +: Width]
//   out_valid_o  output beat valid
//   out_ready_i  downstream accepts the output beat
//   out_data_o   output payload
//   cfg_valid_i  request to load a new delay
//   cfg_ready_o  delay load accepted (only when the pipe is empty and idle)
//   cfg_delay_i  requested delay; values above MaxDelay saturate
//   delay_o      currently active delay
//   empty_o      no valid beat in any stage
//   occupancy_o  (optional) number of valid stages
// -----------------------------------------------------------------------------
module auteur_delay_align #(
    parameter int NumLanes     = 4,
    parameter int Width        = 16,
    parameter int MaxDelay     = 8,
    parameter int DefaultDelay = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [NumLanes*Width-1:0]         in_data_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [NumLanes*Width-1:0]         out_data_o,
    input  logic                              cfg_valid_i,
    output logic                              cfg_ready_o,
    input  logic [$clog2(MaxDelay+1)-1:0]     cfg_delay_i,
    output logic [$clog2(MaxDelay+1)-1:0]     delay_o,
    output logic                              empty_o
`ifdef AUTEUR_DELAY_ALIGN_OCCUPANCY_EN
    ,
    output logic [$clog2(MaxDelay+1)-1:0]     occupancy_o
`endif
);

    localparam int DW = $clog2(MaxDelay + 1);
    localparam int BW = NumLanes * Width;

    function automatic logic [DW-1:0] sat_delay(input logic [DW-1:0] d);
        return (d > DW'(MaxDelay)) ? DW'(MaxDelay) : d;
    endfunction

    logic [DW-1:0]   delay_q;
    logic [MaxDelay-1:0] vld_p;
    logic [BW-1:0]   data_p [MaxDelay];

    logic            bypass;
    logic            tap_vld;
    logic [BW-1:0]   tap_data;
    logic            advance;
    logic            in_acc;
    logic            cfg_acc;

    assign bypass = (delay_q == '0);

    // Output tap: stage D-1 for the active delay D.
    always_comb begin
        tap_vld  = 1'b0;
        tap_data = '0;
        for (int i = 0; i < MaxDelay; i++) begin
            if (DW'(i + 1) == delay_q) begin
                tap_vld  = vld_p[i];
                tap_data = data_p[i];
            end
        end
    end

    assign out_valid_o = bypass ? in_valid_i : tap_vld;
    assign out_data_o  = bypass ? in_data_i  : tap_data;

    // A stall anywhere freezes the whole pipe, which keeps lanes in lockstep.
    assign advance    = !out_valid_o || out_ready_i;
    assign in_ready_o = bypass ? out_ready_i : (advance && !flush_i);
    assign in_acc     = in_valid_i && in_ready_o;

    assign empty_o     = ~|vld_p;
    assign cfg_ready_o = empty_o && !in_valid_i && !flush_i;
    assign cfg_acc     = cfg_valid_i && cfg_ready_o;
    assign delay_o     = delay_q;

    // Stage boundary p0..p(MaxDelay-1): valid bits, reset and flushed.
    // Stages at or beyond the active delay are forced invalid.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_p <= '0;
        end else if (flush_i) begin
            vld_p <= '0;
        end else if (!bypass && advance) begin
            vld_p[0] <= in_acc;
            for (int i = 1; i < MaxDelay; i++) begin
                vld_p[i] <= (DW'(i) < delay_q) ? vld_p[i-1] : 1'b0;
            end
        end
    end

    // Stage boundary p0..p(MaxDelay-1): payload, shifted with the valids.
    always_ff @(posedge clk_i) begin
        if (!bypass && advance) begin
            data_p[0] <= in_data_i;
            for (int i = 1; i < MaxDelay; i++) begin
                data_p[i] <= data_p[i-1];
            end
        end
    end

    // A new delay is loaded only while the pipe is empty and idle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            delay_q <= DW'(DefaultDelay);
        end else if (cfg_acc) begin
            delay_q <= sat_delay(cfg_delay_i);
        end
    end

`ifdef AUTEUR_DELAY_ALIGN_OCCUPANCY_EN
    logic [DW-1:0] occ_q;
    logic          out_hs;

    assign out_hs      = out_valid_o && out_ready_i;
    assign occupancy_o = occ_q;

    // In bypass an accept and an output handshake always coincide, so the
    // count stays at zero there.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            occ_q <= '0;
        end else begin
            case ({in_acc, out_hs})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end
`endif

endmodule
